// File: rtl/key_debounce_pkg.sv
// Shared state encoding and counter sizing for the multi-channel key debouncer.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      P_FILTER = 2'd1,
      WAIT_R   = 2'd2,
      R_FILTER = 2'd3
   } deb_state_e;

   // Counter must hold CNT_MAX-1; never let it collapse below one bit.
   function automatic int cnt_width(input int cnt_max);
      int w;
      w = $clog2(cnt_max);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: synchroniser, polarity normalise, press/release filter FSM,
// stable-sample counter and registered level/pulse outputs.
//
//   state    | meaning
//   IDLE     | key released and accepted as released
//   P_FILTER | pressed level seen, counting stable pressed samples
//   WAIT_R   | press accepted, holding until a released level appears
//   R_FILTER | released level seen, counting stable released samples
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int CNT_MAX     = 100_000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic state_o,
   output logic press_o,
   output logic release_o,
   output logic press_d_o,
   output logic release_d_o
);

   localparam int                CNT_W    = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic              REL_LVL  = ACTIVE_LOW;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   pressed;
   deb_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{REL_LVL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
      end
   end

   assign pressed = sync_q[SYNC_STAGES-1] ^ REL_LVL;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   // Every state change clears the counter, so each filter starts from zero.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pressed) begin
               state_d = P_FILTER;
               cnt_d   = '0;
            end
         end
         P_FILTER: begin
            if (!pressed) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = WAIT_R;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_R: begin
            if (!pressed) begin
               state_d = R_FILTER;
               cnt_d   = '0;
            end
         end
         R_FILTER: begin
            if (pressed) begin
               state_d = WAIT_R;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign state_o     = level_q;
   assign press_o     = press_q;
   assign release_o   = release_q;
   assign press_d_o   = press_d;
   assign release_d_o = release_d;

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel key debouncer top: one filter channel per key plus a registered
// any-event flag aligned with the per-channel pulses.
module key_debounce_multi
   import key_debounce_pkg::*;
#(
   parameter int N_KEYS      = 4,
   parameter int CNT_MAX     = 100_000,
   parameter bit ACTIVE_LOW  = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic              key_event
);

   if (CNT_MAX < 2) begin : g_bad_cnt_max
      $error("key_debounce_multi: CNT_MAX must be >= 2");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("key_debounce_multi: SYNC_STAGES must be >= 2");
   end
   if (N_KEYS < 1) begin : g_bad_n_keys
      $error("key_debounce_multi: N_KEYS must be >= 1");
   end

   logic [N_KEYS-1:0] press_d;
   logic [N_KEYS-1:0] release_d;
   logic              key_event_q;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
      key_debounce_chan #(
         .CNT_MAX     (CNT_MAX),
         .ACTIVE_LOW  (ACTIVE_LOW),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk_i       (clk),
         .rst_i       (rst),
         .key_i       (key_in[k]),
         .state_o     (key_state[k]),
         .press_o     (key_press[k]),
         .release_o   (key_release[k]),
         .press_d_o   (press_d[k]),
         .release_d_o (release_d[k])
      );
   end

   // Registered from next-state pulses so it lands in the same cycle as them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_event_q <= 1'b0;
      end else begin
         key_event_q <= |(press_d | release_d);
      end
   end

   assign key_event = key_event_q;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench: stimulus queues expected pulse cycles/values, negedge
// monitors pop and compare whenever a debouncer presents an event.
`timescale 1ns/1ps
module tb_key_debounce_multi;

   localparam int LAT = 2 + 8 + 1;

   typedef struct {
      int         cyc;
      logic [3:0] pr;
      logic [3:0] rl;
      logic [3:0] st;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] ka;
   logic [3:0] a_state, a_press, a_release;
   logic       a_event;
   logic [0:0] kb;
   logic [0:0] b_state, b_press, b_release;
   logic       b_event;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_miss = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [3:0] mst;
   int   c0;

   key_debounce_multi #(.N_KEYS(4), .CNT_MAX(8), .ACTIVE_LOW(1'b1), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .rst(rst), .key_in(ka), .key_state(a_state),
      .key_press(a_press), .key_release(a_release), .key_event(a_event));

   key_debounce_multi #(.N_KEYS(1), .CNT_MAX(8), .ACTIVE_LOW(1'b0), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .rst(rst), .key_in(kb), .key_state(b_state),
      .key_press(b_press), .key_release(b_release), .key_event(b_event));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_miss++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic push_a(input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] st);
      exp_t e;
      e.cyc = cyc + LAT; e.pr = pr; e.rl = rl; e.st = st;
      qa.push_back(e);
   endtask

   task automatic push_b(input logic pr, input logic rl, input logic st);
      exp_t e;
      e.cyc = cyc + LAT; e.pr = {3'b0, pr}; e.rl = {3'b0, rl}; e.st = {3'b0, st};
      qb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (a_event || a_press != 0 || a_release != 0)) begin
         if (qa.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL a_spurious: press=%b release=%b event=%b at cycle %0d, required no event",
                     a_press, a_release, a_event, cyc);
         end else begin
            e = qa.pop_front();
            chk("a_cycle", cyc, e.cyc);
            chk("a_press", int'(a_press), int'(e.pr));
            chk("a_release", int'(a_release), int'(e.rl));
            chk("a_state", int'(a_state), int'(e.st));
            chk("a_event", int'(a_event), 1);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (b_event || b_press != 0 || b_release != 0)) begin
         if (qb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL b_spurious: press=%b release=%b event=%b at cycle %0d, required no event",
                     b_press, b_release, b_event, cyc);
         end else begin
            e = qb.pop_front();
            chk("b_cycle", cyc, e.cyc);
            chk("b_press", int'(b_press), int'(e.pr[0]));
            chk("b_release", int'(b_release), int'(e.rl[0]));
            chk("b_state", int'(b_state), int'(e.st[0]));
            chk("b_event", int'(b_event), 1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d, required bench completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ka  = 4'hF;
      kb  = 1'b1;
      mst = 4'h0;
      idle(3);
      chk("rst_a_state", int'(a_state), 0);
      chk("rst_a_press", int'(a_press), 0);
      chk("rst_a_release", int'(a_release), 0);
      chk("rst_a_event", int'(a_event), 0);
      chk("rst_b_state", int'(b_state), 0);

      // polarity: pin already high (pressed) at reset must still be filtered
      rst = 1'b0;
      push_b(1'b1, 1'b0, 1'b1);
      idle(15);
      kb = 1'b0;
      push_b(1'b0, 1'b1, 1'b0);
      idle(15);

      // clean press/release on channel 0
      ka[0] = 1'b0; mst[0] = 1'b1;
      push_a(4'b0001, 4'b0000, mst);
      idle(15);
      chk("hold_state0", int'(a_state), 1);
      ka[0] = 1'b1; mst[0] = 1'b0;
      push_a(4'b0000, 4'b0001, mst);
      idle(15);

      // press bounce on channel 1
      ka[1] = 1'b0; idle(5);
      ka[1] = 1'b1; idle(3);
      ka[1] = 1'b0; mst[1] = 1'b1;
      push_a(4'b0010, 4'b0000, mst);
      idle(15);

      // release bounce on channel 2
      ka[2] = 1'b0; mst[2] = 1'b1;
      push_a(4'b0100, 4'b0000, mst);
      idle(15);
      ka[2] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("glitch_state2", int'(a_state[2]), 1);
      end
      ka[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("glitch_state2", int'(a_state[2]), 1);
      end
      ka[2] = 1'b1; mst[2] = 1'b0;
      push_a(4'b0000, 4'b0100, mst);
      idle(15);
      ka[1] = 1'b1; mst[1] = 1'b0;
      push_a(4'b0000, 4'b0010, mst);
      idle(15);

      // simultaneous press and release on channels 0 and 3
      ka[0] = 1'b0; ka[3] = 1'b0; mst = 4'b1001;
      push_a(4'b1001, 4'b0000, mst);
      idle(15);
      ka[0] = 1'b1; ka[3] = 1'b1; mst = 4'b0000;
      push_a(4'b0000, 4'b1001, mst);
      idle(15);

      // reset while ch1 is held (WAIT_R) and ch0 is mid-filter (cnt=5)
      ka[1] = 1'b0; mst[1] = 1'b1;
      push_a(4'b0010, 4'b0000, mst);
      idle(15);
      ka[0] = 1'b0;
      c0 = cyc;
      idle(8);
      chk("pre_rst_cycle", cyc - c0, 8);
      chk("pre_rst_state", int'(a_state), 2);
      rst = 1'b1;
      ka[0] = 1'b1;
      #1;
      chk("midrst_state", int'(a_state), 0);
      chk("midrst_press", int'(a_press), 0);
      chk("midrst_release", int'(a_release), 0);
      chk("midrst_event", int'(a_event), 0);
      idle(3);
      rst = 1'b0;
      mst = 4'b0010;
      push_a(4'b0010, 4'b0000, mst);
      idle(15);
      ka[1] = 1'b1; mst = 4'b0000;
      push_a(4'b0000, 4'b0010, mst);
      idle(15);

      chk("qa_drained", qa.size(), 0);
      chk("qb_drained", qb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Parametrised N-channel key debouncer with a 2-flop-or-deeper input synchroniser per channel, a four-state press/release filter FSM per channel, and registered level and one-cycle press/release event outputs. It sits between raw board key pins and the control logic. It replaces single-key, hard-coded debouncing with configurable key count, filter length, input polarity and synchroniser depth.

## Interface
Parameters:
- N_KEYS, 4, number of independent key channels (≥1)
- CNT_MAX, 100_000, consecutive stable clk samples required to accept a press or a release (≥2)
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
- SYNC_STAGES, 2, synchroniser depth per channel (≥2)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- key_in  in  N_KEYS  raw asynchronous key pins
- key_state  out  N_KEYS  debounced level, 1 = pressed
- key_press  out  N_KEYS  one-clk pulse when a press is accepted
- key_release  out  N_KEYS  one-clk pulse when a release is accepted
- key_event  out  1  registered OR of all key_press and key_release bits

## Operation
- Each sync chain resets to the released pin level, which is ACTIVE_LOW. Its output is normalised to pressed = 1 (p).
- Each channel has a counter of width $clog2(CNT_MAX). The counter clears to 0 on every FSM state change.
- FSM states: IDLE=0, P_FILTER=1, WAIT_R=2, R_FILTER=3. Transitions:
  - IDLE: p=1 → P_FILTER. Otherwise stay.
  - P_FILTER: p=0 → IDLE (bounce rejected, no output). p=1 and cnt==CNT_MAX-1 → WAIT_R, key_state←1, key_press pulse. Otherwise cnt++.
  - WAIT_R: p=0 → R_FILTER. Otherwise stay, key_state held at 1.
  - R_FILTER: p=1 → WAIT_R (release bounce rejected, key_state stays 1). p=0 and cnt==CNT_MAX-1 → IDLE, key_state←0, key_release pulse. Otherwise cnt++.
- The counter never exceeds CNT_MAX-1. There is no wrap-around.
- Channels are fully independent. Simultaneous events on several channels pulse in the same cycle.
- key_press and key_release of the same channel are never both high.

## Timing
- Reset values: all outputs 0, all FSMs IDLE, all counters 0, sync flops at the released level.
- Edge 1 is the first edge that samples a stable raw change. The pulse and the key_state change are visible after edge SYNC_STAGES+CNT_MAX+1. Press and release latency are identical.
- key_event rises in the same cycle as the pulses that cause it. It has no extra latency because it is registered from the next-state pulses.
- Pulses are exactly 1 clk wide.
- A bounce shorter than CNT_MAX synchronised samples never produces a pulse.
- rst asserted mid-filter or mid-hold forces the reset values immediately. A key still held after reset is re-filtered from IDLE and generates a fresh key_press. No key_release is generated for the press that was interrupted.

## Structure
- Package key_debounce_pkg holds the 2-bit state localparams (IDLE, P_FILTER, WAIT_R, R_FILTER) and a cnt_width(CNT_MAX) function.
- Sub-module key_debounce_chan holds the synchroniser, polarity normalise, FSM, counter and registered outputs for one key. The top generates N_KEYS instances and the key_event OR register.
- Elaboration-time checks: CNT_MAX≥2, SYNC_STAGES≥2, N_KEYS≥1.

## Test plan
Bench parameters: N_KEYS=4, CNT_MAX=8, ACTIVE_LOW=1, SYNC_STAGES=2.
- Clean press: key_in[0] 1→0 held → key_press[0]=1 for one clk after edge 11, key_state[0]=1 from then on, key_event=1 in the same cycle.
- Press bounce: key_in[1] low for 5 clk, high for 3, then low held → no pulse during the glitch. key_press[1] appears 11 edges after the final falling sample.
- Release bounce: held key_in[2] goes high for 4 clk, low again, then high held → key_state[2] stays 1 through the glitch. key_release[2] follows 11 edges after the final rise.
- Simultaneous press: key_in[0] and key_in[3] fall on the same edge → both key_press bits pulse in the same cycle, and key_event is a single one-clk pulse.
- Reset mid-operation: assert rst while channel 0 is in P_FILTER with cnt=5, and separately while channel 1 is in WAIT_R → all outputs go to 0 at once with no release pulse. After rst is released, the still-held channel 1 produces key_press 11 edges later.
- Polarity: with ACTIVE_LOW=0, a key_in[0] 0→1 press produces key_press[0] after edge 11, and an idle-high pin at reset produces no pulse until it has been filtered.
